// File: rtl/gs_residual.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : gs_residual                                             |
// | Purpose  : Gram-Schmidt update step. Given unit vector A and       |
// |            column B (4 packed signed fixed-point lanes), computes  |
// |            r = <A,B>, U = B - r*A and ||U||^2 over a fixed         |
// |            six-cycle pipeline of FSM states.                       |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module gs_residual #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4*W-1:0]   A,
  input  logic [4*W-1:0]   B,
  output logic             busy,
  output logic             done,
  output logic [4*W-1:0]   U,
  output logic [W-1:0]     dot,
  output logic [W-1:0]     norm2
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DOT   = 3'd1,
    S_SUM   = 3'd2,
    S_SCALE = 3'd3,
    S_SUB   = 3'd4,
    S_NORM  = 3'd5,
    S_NSUM  = 3'd6
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_a [4];
  logic [W-1:0]   r_b [4];
  logic [W-1:0]   r_p [4];
  logic [W-1:0]   r_s [4];
  logic [W-1:0]   r_u [4];
  logic [W-1:0]   r_q [4];
  logic [W-1:0]   r_r;

  // Fixed-point multiply: full 2W-bit signed product, floor shift by FRAC,
  // keep the low W bits (wraps, no saturation or rounding).
  function automatic logic [W-1:0] mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] prod;
    prod = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
    prod = prod >>> FRAC;
    return prod[W-1:0];
  endfunction

  // Operation sequencer: one datapath step per state, outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      U       <= '0;
      dot     <= '0;
      norm2   <= '0;
      r_r     <= '0;
      for (int i = 0; i < 4; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
        r_p[i] <= '0;
        r_s[i] <= '0;
        r_u[i] <= '0;
        r_q[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Lane 0 sits in the most significant slice of the bus.
            for (int i = 0; i < 4; i++) begin
              r_a[i] <= A[(3-i)*W +: W];
              r_b[i] <= B[(3-i)*W +: W];
            end
            busy    <= 1'b1;
            r_state <= S_DOT;
          end
        end
        S_DOT: begin
          for (int i = 0; i < 4; i++) r_p[i] <= mul(r_a[i], r_b[i]);
          r_state <= S_SUM;
        end
        S_SUM: begin
          r_r     <= r_p[0] + r_p[1] + r_p[2] + r_p[3];
          r_state <= S_SCALE;
        end
        S_SCALE: begin
          for (int i = 0; i < 4; i++) r_s[i] <= mul(r_r, r_a[i]);
          r_state <= S_SUB;
        end
        S_SUB: begin
          for (int i = 0; i < 4; i++) r_u[i] <= r_b[i] - r_s[i];
          r_state <= S_NORM;
        end
        S_NORM: begin
          for (int i = 0; i < 4; i++) r_q[i] <= mul(r_u[i], r_u[i]);
          r_state <= S_NSUM;
        end
        S_NSUM: begin
          U       <= {r_u[0], r_u[1], r_u[2], r_u[3]};
          dot     <= r_r;
          norm2   <= r_q[0] + r_q[1] + r_q[2] + r_q[3];
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          // Unreachable encoding: recover to idle.
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
